led_pio_blink: RTL and testbench
================================

// Module: led_pio_blink
// PURPOSE
//  Parametrised Avalon-MM output PIO for board LEDs; successor to the fixed 9-bit write-only LED port.
//  Adds: configurable width, atomic bit set/clear, per-bit blink mode, programmable blink period, readable phase.
//  Sits on the system interconnect as a 0-wait-state slave; out_port drives LED pins directly.
// PARAMETERS
//  WIDTH          9          number of output bits (1..32)
//  CNT_W          24         blink prescaler counter width (1..32)
//  RESET_VALUE    0          DATA register value after reset (WIDTH bits)
//  RESET_PERIOD   2500000    BLINK_PERIOD value after reset (CNT_W bits)
// PORTS
//  clk        in   1      system clock; all logic on rising edge
//  reset_n    in   1      reset, synchronous, active-low
//  address    in   3      word address of register
//  chipselect in   1      slave select
//  write_n    in   1      write strobe, active-low, qualified by chipselect
//  writedata  in   32     write data; bits above register width ignored
//  readdata   out  32     read data, combinational from address; unused bits 0
//  out_port   out  WIDTH  LED drive
// BEHAVIOUR
//  Write = chipselect & ~write_n, takes effect at next clk edge; read latency 0, no wait states.
//  Register map (addr: name, access):
//   0 DATA    RW  data <= writedata[WIDTH-1:0]
//   1 MODE    RW  per-bit: 0 static, 1 blink
//   2 PERIOD  RW  prescaler terminal count, CNT_W bits
//   3 PHASE   RO  bit0 = current blink phase; writes ignored
//   4 SET     WO  data <= data | writedata[WIDTH-1:0]; reads 0
//   5 CLEAR   WO  data <= data & ~writedata[WIDTH-1:0]; reads 0
//   6,7       reserved: reads 0, writes ignored
//  Reset (reset_n=0 at edge): data=RESET_VALUE, mode=0, period=RESET_PERIOD, cnt=0, phase=1.
//   Reset dominates any concurrent write. out_port after reset = RESET_VALUE.
//  Prescaler: cnt increments each clk; when cnt==period: cnt<=0, phase<=~phase.
//   Toggle interval = period+1 cycles; full blink cycle = 2*(period+1).
//   period==0: cnt held 0, phase held 1 (blinking bits appear steady on).
//   Write to PERIOD: period updated, cnt<=0, phase<=1 in same edge (restarts on-phase).
//   Period written below current cnt cannot strand counter: restart rule covers it.
//  Output: out_port = data & (~mode | {WIDTH{phase}}); combinational from registers, no extra latency.
//   Write to DATA/SET/CLEAR/MODE visible on out_port the cycle after the write edge.
//  Writes to MODE do not disturb cnt/phase.
//  Only one register written per cycle (single address); no SET/CLEAR conflict possible.
//  readdata for DATA/MODE/PERIOD zero-extended to 32 bits; reflects register value pre-edge.
// STRUCTURE
//  Shared package/include (led_pio_pkg): localparams ADDR_DATA=0, ADDR_MODE=1, ADDR_PERIOD=2,
//   ADDR_PHASE=3, ADDR_SET=4, ADDR_CLEAR=5, and address width 3.
//  Sub-module blink_prescaler (params CNT_W, RESET_PERIOD): holds period, cnt, phase;
//   inputs clk, reset_n, period_wr, period_in; outputs period, phase.
//  Top: register decode, DATA/MODE regs, read mux, output gating.
// TESTING
//  1 Reset with RESET_VALUE=9'h0A5 -> out_port=0x0A5, MODE/PHASE read 0/1, PERIOD reads RESET_PERIOD.
//  2 Write DATA=0x1FF, SET 0x000, CLEAR 0x0F0 -> DATA reads 0x10F; SET 0x020 -> 0x12F; out_port tracks next cycle.
//  3 PERIOD=3, MODE=0x001, DATA=0x003 -> bit0 toggles every 4 cycles (on 4, off 4), bit1 steady 1, PHASE matches.
//  4 PERIOD=0 with MODE=0x1FF, DATA=0x1FF -> out_port steady 0x1FF, cnt stays 0 over 100 cycles.
//  5 Mid-blink (phase=0, cnt=2, period=5) write PERIOD=1 -> next cycle phase=1, cnt=0; toggles every 2 cycles.
//  6 Assert reset_n=0 for one edge concurrent with DATA write 0x055 -> registers at reset values; write lost.
//    Also: write/read addr 6,7 and read 4,5 -> readdata 0, no register changes.

Source files
------------

// File: rtl/led_pio_pkg.sv
// Register map shared by the LED PIO top and its testbench.
package led_pio_pkg;
  localparam int ADDR_W = 3;
  localparam logic [ADDR_W-1:0] ADDR_DATA   = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_MODE   = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_PHASE  = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_SET    = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_CLEAR  = 3'd5;
endpackage

// File: rtl/blink_prescaler.sv
// Blink timebase: phase toggles every period+1 clocks; a period write restarts the on-phase.
module blink_prescaler #(
  parameter int               CNT_W        = 24,
  parameter logic [CNT_W-1:0] RESET_PERIOD = CNT_W'(2500000)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             period_wr,
  input  logic [CNT_W-1:0] period_in,
  output logic [CNT_W-1:0] period,
  output logic             phase
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      period <= RESET_PERIOD;
      cnt    <= '0;
      phase  <= 1'b1;
    end else if (period_wr) begin
      // restarting here also covers a new period below the running count
      period <= period_in;
      cnt    <= '0;
      phase  <= 1'b1;
    end else if (period == '0) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == period) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/led_pio_blink.sv
// Avalon-MM LED output port with set/clear, per-bit blink and programmable blink period.
module led_pio_blink
  import led_pio_pkg::*;
#(
  parameter int               WIDTH        = 9,
  parameter int               CNT_W        = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter logic [CNT_W-1:0] RESET_PERIOD = CNT_W'(2500000)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port
);
  logic [WIDTH-1:0] data, mode;
  logic [CNT_W-1:0] period;
  logic             phase;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^{writedata, 1'b0};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data <= RESET_VALUE;
      mode <= '0;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:  data <= writedata[WIDTH-1:0];
        ADDR_MODE:  mode <= writedata[WIDTH-1:0];
        ADDR_SET:   data <= data | writedata[WIDTH-1:0];
        ADDR_CLEAR: data <= data & ~writedata[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  blink_prescaler #(
    .CNT_W       (CNT_W),
    .RESET_PERIOD(RESET_PERIOD)
  ) u_presc (
    .clk      (clk),
    .reset_n  (reset_n),
    .period_wr(wr_en && (address == ADDR_PERIOD)),
    .period_in(writedata[CNT_W-1:0]),
    .period   (period),
    .phase    (phase)
  );

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0] = data;
      ADDR_MODE:   readdata[WIDTH-1:0] = mode;
      ADDR_PERIOD: readdata[CNT_W-1:0] = period;
      ADDR_PHASE:  readdata[0]         = phase;
      default: ;
    endcase
  end

  // static bits pass data through; blink bits are gated by the shared phase
  assign out_port = data & (~mode | {WIDTH{phase}});
endmodule

// File: tb/tb_led_pio_blink.sv
// Directed bench for led_pio_blink: register access, set/clear, blink timing, reset dominance.
module tb_led_pio_blink;
  import led_pio_pkg::*;

  localparam int          WIDTH  = 9;
  localparam int          CNT_W  = 24;
  localparam logic [8:0]  RV     = 9'h0A5;
  localparam logic [23:0] RP     = 24'd2500000;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic [WIDTH-1:0]  out_port;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  led_pio_blink #(
    .WIDTH       (WIDTH),
    .CNT_W       (CNT_W),
    .RESET_VALUE (RV),
    .RESET_PERIOD(RP)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // called at a negedge; the write lands on the following posedge
  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    chk(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  initial begin
    logic ph;
    // 1: reset values
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    chk("rst_out", 32'(out_port), 32'h0A5);
    rd("rst_data", ADDR_DATA, 32'h0A5);
    rd("rst_mode", ADDR_MODE, 32'h0);
    rd("rst_phase", ADDR_PHASE, 32'h1);
    rd("rst_period", ADDR_PERIOD, 32'd2500000);

    // 2: data write (upper bits ignored), set, clear
    wr(ADDR_DATA, 32'hFFFF_F1FF);
    chk("data_out", 32'(out_port), 32'h1FF);
    rd("data_rd", ADDR_DATA, 32'h1FF);
    wr(ADDR_SET, 32'h0);
    chk("set0_out", 32'(out_port), 32'h1FF);
    wr(ADDR_CLEAR, 32'h0F0);
    chk("clr_out", 32'(out_port), 32'h10F);
    rd("clr_rd", ADDR_DATA, 32'h10F);
    wr(ADDR_SET, 32'h020);
    chk("set_out", 32'(out_port), 32'h12F);
    rd("set_rd", ADDR_DATA, 32'h12F);
    rd("set_reg_rd", ADDR_SET, 32'h0);
    rd("clr_reg_rd", ADDR_CLEAR, 32'h0);

    // 3: period 3, bit0 blinks 4 on / 4 off, bit1 static
    wr(ADDR_MODE, 32'h001);
    wr(ADDR_DATA, 32'h003);
    wr(ADDR_PERIOD, 32'd3);
    for (int i = 0; i < 16; i++) begin
      ph = ((i / 4) % 2) == 0;
      chk($sformatf("blk3_out%0d", i), 32'(out_port), {30'b0, 1'b1, ph});
      rd($sformatf("blk3_ph%0d", i), ADDR_PHASE, {31'b0, ph});
      @(negedge clk);
    end

    // 4: period 0 holds phase on, counter idle
    wr(ADDR_MODE, 32'h1FF);
    wr(ADDR_DATA, 32'h1FF);
    wr(ADDR_PERIOD, 32'd0);
    for (int i = 0; i < 100; i++) begin
      chk("p0_out", 32'(out_port), 32'h1FF);
      chk("p0_cnt", 32'(dut.u_presc.cnt), 32'h0);
      @(negedge clk);
    end

    // 5: shrink period mid-blink
    wr(ADDR_PERIOD, 32'd5);
    repeat (8) @(negedge clk);
    chk("mid_phase", 32'(dut.u_presc.phase), 32'h0);
    chk("mid_cnt", 32'(dut.u_presc.cnt), 32'h2);
    chk("mid_out", 32'(out_port), 32'h000);
    wr(ADDR_PERIOD, 32'd1);
    chk("restart_cnt", 32'(dut.u_presc.cnt), 32'h0);
    for (int i = 0; i < 8; i++) begin
      ph = ((i / 2) % 2) == 0;
      chk($sformatf("p1_out%0d", i), 32'(out_port), ph ? 32'h1FF : 32'h0);
      @(negedge clk);
    end

    // 6: reset dominates concurrent write
    reset_n = 1'b0;
    wr(ADDR_DATA, 32'h055);
    reset_n = 1'b1;
    chk("rst2_out", 32'(out_port), 32'h0A5);
    rd("rst2_data", ADDR_DATA, 32'h0A5);
    rd("rst2_mode", ADDR_MODE, 32'h0);
    rd("rst2_period", ADDR_PERIOD, 32'd2500000);
    rd("rst2_phase", ADDR_PHASE, 32'h1);

    // reserved / read-only addresses
    wr(3'd6, 32'hFFFF_FFFF);
    wr(3'd7, 32'hFFFF_FFFF);
    wr(ADDR_PHASE, 32'h0);
    rd("rsv6", 3'd6, 32'h0);
    rd("rsv7", 3'd7, 32'h0);
    rd("rsv_data", ADDR_DATA, 32'h0A5);
    rd("rsv_mode", ADDR_MODE, 32'h0);
    rd("rsv_period", ADDR_PERIOD, 32'd2500000);
    rd("rsv_phase", ADDR_PHASE, 32'h1);
    chk("rsv_out", 32'(out_port), 32'h0A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
